// File: rtl/sync_fifo_buffer_pkg.sv
// Shared types and helpers for the single-clock FIFO.
package fifo_pkg;

   typedef enum logic [0:0] {
      READ_MODE_FWFT       = 1'b0,
      READ_MODE_REGISTERED = 1'b1
   } read_mode_e;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_DEPTH      = 256;

   // Occupancy ranges over 0..depth inclusive, hence depth+1 codes.
   function automatic int fifo_count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo_buffer_if.sv
// Producer/consumer bundle of the single-clock FIFO.
interface sync_fifo_buffer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256
);
   import fifo_pkg::*;

   localparam int CW = fifo_count_width(DEPTH);

   logic                  flush;
   logic                  write_enable;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  read_enable;
   logic [DATA_WIDTH-1:0] read_data;
   logic [CW-1:0]         count;
   logic                  empty;
   logic                  full;
   logic                  almost_empty;
   logic                  almost_full;
   logic                  overflow;
   logic                  underflow;

   // The user side of the FIFO.
   modport master (
      output flush, write_enable, write_data, read_enable,
      input  read_data, count, empty, full, almost_empty, almost_full,
             overflow, underflow
   );

   // The FIFO itself.
   modport slave (
      input  flush, write_enable, write_data, read_enable,
      output read_data, count, empty, full, almost_empty, almost_full,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_buffer_storage.sv
// Word storage: one synchronous write port, one asynchronous read port.
// Kept separate so a vendor block RAM can be dropped in later.
module fifo_storage_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256
) (
   input  logic                          clk,
   input  logic                          wr_en,
   input  logic [$clog2(DEPTH)-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0]      rd_addr,
   output logic [DATA_WIDTH-1:0]         rd_data
);
   logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

   // Contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_reg[rd_addr];
endmodule

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with FWFT or registered read, occupancy count,
// almost thresholds, sticky error flags and synchronous flush.
module sync_fifo_buffer
   import fifo_pkg::*;
#(
   parameter int         DATA_WIDTH         = DEFAULT_DATA_WIDTH,
   parameter int         DEPTH              = DEFAULT_DEPTH,
   parameter read_mode_e READ_MODE          = READ_MODE_FWFT,
   parameter int         ALMOST_FULL_LEVEL  = DEPTH - 1,
   parameter int         ALMOST_EMPTY_LEVEL = 1
) (
   input logic              clk,
   input logic              reset,
   sync_fifo_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = fifo_count_width(DEPTH);

   if (DEPTH < 2) begin : g_err_depth
      $error("sync_fifo_buffer: DEPTH must be at least 2");
   end
   if (ALMOST_FULL_LEVEL > DEPTH) begin : g_err_af
      $error("sync_fifo_buffer: ALMOST_FULL_LEVEL exceeds DEPTH");
   end
   if (ALMOST_EMPTY_LEVEL >= DEPTH) begin : g_err_ae
      $error("sync_fifo_buffer: ALMOST_EMPTY_LEVEL must be below DEPTH");
   end

   logic [PW-1:0]         wr_ptr_reg;
   logic [PW-1:0]         rd_ptr_reg;
   logic [CW-1:0]         count_reg;
   logic                  overflow_reg;
   logic                  underflow_reg;
   logic                  empty_w;
   logic                  full_w;
   logic                  rd_acc;
   logic                  wr_acc;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Non-power-of-two depths need an explicit wrap.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign empty_w = (count_reg == '0);
   assign full_w  = (count_reg == CW'(DEPTH));
   // A read on a full FIFO frees the slot the write needs.
   assign rd_acc  = bus.read_enable && !empty_w;
   assign wr_acc  = bus.write_enable && (!full_w || rd_acc);

   assign bus.count        = count_reg;
   assign bus.empty        = empty_w;
   assign bus.full         = full_w;
   assign bus.almost_empty = (count_reg <= CW'(ALMOST_EMPTY_LEVEL));
   assign bus.almost_full  = (count_reg >= CW'(ALMOST_FULL_LEVEL));
   assign bus.overflow     = overflow_reg;
   assign bus.underflow    = underflow_reg;

   fifo_storage_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_acc && !reset && !bus.flush),
      .wr_addr (wr_ptr_reg),
      .wr_data (bus.write_data),
      .rd_addr (rd_ptr_reg),
      .rd_data (ram_rdata)
   );

   // Pointers, occupancy and sticky error flags; reset beats flush beats traffic.
   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_reg <= ptr_next(wr_ptr_reg);
         end
         if (rd_acc) begin
            rd_ptr_reg <= ptr_next(rd_ptr_reg);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (bus.write_enable && !wr_acc) begin
            overflow_reg <= 1'b1;
         end
         if (bus.read_enable && !rd_acc) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   if (READ_MODE == READ_MODE_FWFT) begin : g_fwft
      // Head word is visible without latency; zero when nothing is stored.
      assign bus.read_data = empty_w ? '0 : ram_rdata;
   end else begin : g_registered
      logic [DATA_WIDTH-1:0] read_data_reg;

      // Capture the popped word; hold it otherwise, including across flush.
      always_ff @(posedge clk) begin
         if (reset) begin
            read_data_reg <= '0;
         end else if (!bus.flush && rd_acc) begin
            read_data_reg <= ram_rdata;
         end
      end

      assign bus.read_data = read_data_reg;
   end
endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Self-checking bench: one FWFT and one REGISTERED instance (DEPTH=5)
// driven with identical stimulus and checked against a queue model.
module tb_sync_fifo_buffer;
   import fifo_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 5;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   sync_fifo_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fw_if ();
   sync_fifo_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) rg_if ();

   sync_fifo_buffer #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_MODE(READ_MODE_FWFT),
      .ALMOST_FULL_LEVEL(4), .ALMOST_EMPTY_LEVEL(1)
   ) u_fw (.clk(clk), .reset(reset), .bus(fw_if));

   sync_fifo_buffer #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_MODE(READ_MODE_REGISTERED),
      .ALMOST_FULL_LEVEL(4), .ALMOST_EMPTY_LEVEL(1)
   ) u_rg (.clk(clk), .reset(reset), .bus(rg_if));

   // Behavioural model: contents as a queue, plus sticky flags and last popped word.
   logic [DW-1:0] mq[$];
   bit            m_ovf, m_unf;
   logic [DW-1:0] m_rd_reg;

   function automatic void model_step(input bit we, input logic [DW-1:0] wd,
                                      input bit re, input bit fl, input bit rs);
      bit rd_ok, wr_ok;
      if (rs) begin
         mq.delete(); m_ovf = 0; m_unf = 0; m_rd_reg = '0;
      end else if (fl) begin
         mq.delete(); m_ovf = 0; m_unf = 0;
      end else begin
         rd_ok = re && (mq.size() > 0);
         wr_ok = we && ((mq.size() < DEPTH) || rd_ok);
         if (re && !rd_ok) m_unf = 1;
         if (we && !wr_ok) m_ovf = 1;
         if (rd_ok) m_rd_reg = mq.pop_front();
         if (wr_ok) mq.push_back(wd);
      end
   endfunction

   // {empty, full, almost_empty, almost_full, overflow, underflow}
   function automatic logic [5:0] exp_flags();
      int n = mq.size();
      return {n == 0, n == DEPTH, n <= 1, n >= 4, m_ovf, m_unf};
   endfunction

   function automatic logic [DW-1:0] exp_head();
      return (mq.size() > 0) ? mq[0] : '0;
   endfunction

   task automatic drive(input bit we, input logic [DW-1:0] wd, input bit re,
                        input bit fl, input bit rs);
      fw_if.write_enable = we; fw_if.write_data = wd;
      fw_if.read_enable = re;  fw_if.flush = fl;
      rg_if.write_enable = we; rg_if.write_data = wd;
      rg_if.read_enable = re;  rg_if.flush = fl;
      reset = rs;
      @(posedge clk);
      model_step(we, wd, re, fl, rs);
      #1;
      fw_if.write_enable = 0; fw_if.read_enable = 0; fw_if.flush = 0;
      rg_if.write_enable = 0; rg_if.read_enable = 0; rg_if.flush = 0;
      reset = 0;
   endtask

   task automatic test_reset();
      drive(0, '0, 0, 0, 1);
      checks++;
      if ({fw_if.empty, fw_if.full, fw_if.almost_empty, fw_if.almost_full,
           fw_if.overflow, fw_if.underflow} !== 6'b101000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 101000",
                  {fw_if.empty, fw_if.full, fw_if.almost_empty, fw_if.almost_full,
                   fw_if.overflow, fw_if.underflow});
      end
      checks++;
      if (fw_if.count !== 3'd0 || rg_if.count !== 3'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d/%0d expected 0", fw_if.count, rg_if.count);
      end
      checks++;
      if (fw_if.read_data !== 8'h00 || rg_if.read_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_rdata: got %h/%h expected 00", fw_if.read_data, rg_if.read_data);
      end
      $display("test_reset done");
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 5; i++) begin
         drive(1, 8'(8'h11 + i), 0, 0, 0);
         if (i == 3) begin
            checks++;
            if (fw_if.almost_full !== 1'b1 || fw_if.full !== 1'b0) begin
               errors++;
               $display("FAIL af_at4: got af=%b full=%b expected af=1 full=0",
                        fw_if.almost_full, fw_if.full);
            end
         end
      end
      checks++;
      if (fw_if.full !== 1'b1 || fw_if.count !== 3'd5) begin
         errors++;
         $display("FAIL full_at5: got full=%b count=%0d expected full=1 count=5",
                  fw_if.full, fw_if.count);
      end
      drive(1, 8'h66, 0, 0, 0);
      checks++;
      if (fw_if.overflow !== 1'b1 || fw_if.count !== 3'd5) begin
         errors++;
         $display("FAIL overflow: got ovf=%b count=%0d expected ovf=1 count=5",
                  fw_if.overflow, fw_if.count);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (fw_if.read_data !== 8'(8'h11 + i)) begin
            errors++;
            $display("FAIL fill_fwft_rd%0d: got %h expected %h", i, fw_if.read_data, 8'(8'h11 + i));
         end
         drive(0, '0, 1, 0, 0);
         checks++;
         if (rg_if.read_data !== 8'(8'h11 + i)) begin
            errors++;
            $display("FAIL fill_reg_rd%0d: got %h expected %h", i, rg_if.read_data, 8'(8'h11 + i));
         end
      end
      checks++;
      if (fw_if.empty !== 1'b1 || fw_if.read_data !== 8'h00) begin
         errors++;
         $display("FAIL drained: got empty=%b rd=%h expected empty=1 rd=00",
                  fw_if.empty, fw_if.read_data);
      end
      $display("test_fill_overflow done");
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) drive(1, 8'(i + 1), 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, '0, 1, 0, 0);
      for (int i = 0; i < 5; i++) drive(1, 8'(8'hA0 + i), 0, 0, 0);
      checks++;
      if (fw_if.full !== 1'b1) begin
         errors++;
         $display("FAIL wrap_full: got %b expected 1", fw_if.full);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (fw_if.read_data !== 8'(8'hA0 + i)) begin
            errors++;
            $display("FAIL wrap_fwft_rd%0d: got %h expected %h", i, fw_if.read_data, 8'(8'hA0 + i));
         end
         drive(0, '0, 1, 0, 0);
         checks++;
         if (rg_if.read_data !== 8'(8'hA0 + i)) begin
            errors++;
            $display("FAIL wrap_reg_rd%0d: got %h expected %h", i, rg_if.read_data, 8'(8'hA0 + i));
         end
      end
      $display("test_wrap done");
   endtask

   task automatic test_full_rw();
      logic [DW-1:0] head;
      drive(0, '0, 0, 1, 0);
      for (int i = 0; i < 5; i++) drive(1, 8'($urandom_range(0, 255)), 0, 0, 0);
      head = mq[0];
      drive(1, 8'h77, 1, 0, 0);
      checks++;
      if (fw_if.count !== 3'd5 || fw_if.full !== 1'b1 || fw_if.overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_rw: got count=%0d full=%b ovf=%b expected 5 1 0",
                  fw_if.count, fw_if.full, fw_if.overflow);
      end
      checks++;
      if (rg_if.read_data !== head) begin
         errors++;
         $display("FAIL full_rw_pop: got %h expected %h", rg_if.read_data, head);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (fw_if.read_data !== exp_head()) begin
            errors++;
            $display("FAIL full_rw_rd%0d: got %h expected %h", i, fw_if.read_data, exp_head());
         end
         if (i == 4) begin
            checks++;
            if (fw_if.read_data !== 8'h77) begin
               errors++;
               $display("FAIL full_rw_tail: got %h expected 77", fw_if.read_data);
            end
         end
         drive(0, '0, 1, 0, 0);
      end
      $display("test_full_rw done");
   endtask

   task automatic test_underflow();
      logic [DW-1:0] prev;
      drive(0, '0, 0, 1, 0);
      prev = rg_if.read_data;
      drive(0, '0, 1, 0, 0);
      checks++;
      if (fw_if.underflow !== 1'b1 || fw_if.count !== 3'd0 || rg_if.read_data !== prev) begin
         errors++;
         $display("FAIL underflow: got unf=%b count=%0d rd=%h expected 1 0 %h",
                  fw_if.underflow, fw_if.count, rg_if.read_data, prev);
      end
      drive(1, 8'h3C, 1, 0, 0);
      checks++;
      if (fw_if.count !== 3'd1 || fw_if.read_data !== 8'h3C || rg_if.read_data !== prev) begin
         errors++;
         $display("FAIL empty_wr_rd: got count=%0d fw=%h rg=%h expected 1 3c %h",
                  fw_if.count, fw_if.read_data, rg_if.read_data, prev);
      end
      drive(0, '0, 1, 0, 0);
      checks++;
      if (rg_if.read_data !== 8'h3C || rg_if.underflow !== 1'b1) begin
         errors++;
         $display("FAIL unf_sticky: got rd=%h unf=%b expected 3c 1", rg_if.read_data, rg_if.underflow);
      end
      drive(0, '0, 0, 1, 0);
      checks++;
      if (fw_if.underflow !== 1'b0 || rg_if.read_data !== 8'h3C) begin
         errors++;
         $display("FAIL unf_flush: got unf=%b rg=%h expected 0 3c", fw_if.underflow, rg_if.read_data);
      end
      $display("test_underflow done");
   endtask

   task automatic test_flush();
      for (int i = 0; i < 6; i++) drive(1, 8'(8'h21 + i), 0, 0, 0);
      drive(0, '0, 1, 0, 0);
      drive(0, '0, 1, 0, 0);
      checks++;
      if (fw_if.count !== 3'd3 || fw_if.overflow !== 1'b1) begin
         errors++;
         $display("FAIL pre_flush: got count=%0d ovf=%b expected 3 1", fw_if.count, fw_if.overflow);
      end
      drive(1, 8'h99, 0, 1, 0);
      checks++;
      if (fw_if.count !== 3'd0 || fw_if.empty !== 1'b1 || fw_if.overflow !== 1'b0) begin
         errors++;
         $display("FAIL flush: got count=%0d empty=%b ovf=%b expected 0 1 0",
                  fw_if.count, fw_if.empty, fw_if.overflow);
      end
      drive(1, 8'h42, 0, 0, 0);
      checks++;
      if (fw_if.count !== 3'd1 || fw_if.read_data !== 8'h42) begin
         errors++;
         $display("FAIL post_flush_wr: got count=%0d rd=%h expected 1 42", fw_if.count, fw_if.read_data);
      end
      drive(0, '0, 1, 0, 0);
      checks++;
      if (rg_if.read_data !== 8'h42 || rg_if.empty !== 1'b1) begin
         errors++;
         $display("FAIL post_flush_rd: got rd=%h empty=%b expected 42 1", rg_if.read_data, rg_if.empty);
      end
      $display("test_flush done");
   endtask

   task automatic test_registered();
      drive(0, '0, 0, 0, 1);
      drive(1, 8'h5A, 0, 0, 0);
      drive(1, 8'hC3, 0, 0, 0);
      checks++;
      if (rg_if.read_data !== 8'h00) begin
         errors++;
         $display("FAIL reg_before_rd: got %h expected 00", rg_if.read_data);
      end
      drive(0, '0, 1, 0, 0);
      checks++;
      if (rg_if.read_data !== 8'h5A || fw_if.read_data !== 8'hC3) begin
         errors++;
         $display("FAIL reg_n1: got rg=%h fw=%h expected 5a c3", rg_if.read_data, fw_if.read_data);
      end
      drive(0, '0, 0, 0, 0);
      checks++;
      if (rg_if.read_data !== 8'h5A) begin
         errors++;
         $display("FAIL reg_hold: got %h expected 5a", rg_if.read_data);
      end
      drive(0, '0, 0, 0, 1);
      checks++;
      if (rg_if.read_data !== 8'h00 || rg_if.count !== 3'd0) begin
         errors++;
         $display("FAIL reg_reset: got rd=%h count=%0d expected 00 0", rg_if.read_data, rg_if.count);
      end
      $display("test_registered done");
   endtask

   task automatic test_random();
      bit we, re, fl, rs;
      logic [DW-1:0] wd;
      logic [5:0] fw_fl, rg_fl;
      for (int n = 0; n < 400; n++) begin
         we = ($urandom_range(0, 99) < 60);
         re = ($urandom_range(0, 99) < 50);
         fl = ($urandom_range(0, 63) == 0);
         rs = ($urandom_range(0, 199) == 0);
         wd = 8'($urandom_range(0, 255));
         drive(we, wd, re, fl, rs);
         fw_fl = {fw_if.empty, fw_if.full, fw_if.almost_empty, fw_if.almost_full,
                  fw_if.overflow, fw_if.underflow};
         rg_fl = {rg_if.empty, rg_if.full, rg_if.almost_empty, rg_if.almost_full,
                  rg_if.overflow, rg_if.underflow};
         checks++;
         if (fw_fl !== exp_flags() || rg_fl !== exp_flags()) begin
            errors++;
            $display("FAIL rnd_flags@%0d: got %b/%b expected %b", n, fw_fl, rg_fl, exp_flags());
         end
         checks++;
         if (fw_if.count !== 3'(mq.size()) || rg_if.count !== 3'(mq.size())) begin
            errors++;
            $display("FAIL rnd_count@%0d: got %0d/%0d expected %0d", n, fw_if.count, rg_if.count, mq.size());
         end
         checks++;
         if (fw_if.read_data !== exp_head()) begin
            errors++;
            $display("FAIL rnd_fwft_rd@%0d: got %h expected %h", n, fw_if.read_data, exp_head());
         end
         checks++;
         if (rg_if.read_data !== m_rd_reg) begin
            errors++;
            $display("FAIL rnd_reg_rd@%0d: got %h expected %h", n, rg_if.read_data, m_rd_reg);
         end
      end
      $display("test_random done");
   endtask

   initial begin
      reset = 1'b0;
      fw_if.flush = 0; fw_if.write_enable = 0; fw_if.write_data = '0; fw_if.read_enable = 0;
      rg_if.flush = 0; rg_if.write_enable = 0; rg_if.write_data = '0; rg_if.read_enable = 0;
      m_ovf = 0; m_unf = 0; m_rd_reg = '0;
      @(negedge clk);
      test_reset();
      test_fill_overflow();
      test_wrap();
      test_full_rw();
      test_underflow();
      test_flush();
      test_registered();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end
endmodule
